// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the MIPS core. It accepts one load/store at a
//   time over a req/ready handshake and serves it from an internal
//   word-addressed RAM after a programmable number of wait states.
//   Misaligned or illegal-size accesses are answered with err and no RAM access.
//
// Parameters
//   ADDR_W : word-address bits, depth = 2**ADDR_W words
//   WAIT   : wait states between acceptance and response (0..15)
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous, active-low reset
//   req    : request valid, held stable until ready
//   we     : 1 = store, 0 = load
//   size   : 00 byte, 01 half, 10 word, 11 illegal
//   addr   : byte address (upper bits alias)
//   wdata  : store data, right-aligned
//   rdata  : load data, zero-extended and right-aligned
//   ready  : one-cycle response strobe
//   err    : with ready, flags a misaligned/illegal access
//   busy   : high from the cycle after acceptance through the ready cycle
module data_mem_responder #(
  parameter int ADDR_W = 6,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int AW    = ADDR_W + 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  // Request captured at acceptance
  logic          we_p0;
  logic [1:0]    size_p0;
  logic [AW-1:0] addr_p0;
  logic [31:0]   wdata_p0;

  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_bad;
  logic [ADDR_W-1:0] sel_idx;
  logic [31:0]   sel_word;
  logic          to_resp;

  // Address bits above the array alias; collected here so dropping them is explicit.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] w;
    w = old;
    case (sz)
      2'b00:   w[{a, 3'b000} +: 8] = wd[7:0];
      2'b01:   w[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] a);
    case (sz)
      2'b00:   extract_load = {24'b0, word[{a, 3'b000} +: 8]};
      2'b01:   extract_load = {16'b0, word[{a[1], 4'b0000} +: 16]};
      default: extract_load = word;
    endcase
  endfunction

  // With WAIT = 0 the response edge is the acceptance edge, so the live
  // inputs are used in IDLE and the captured copy everywhere else.
  always_comb begin
    sel_we    = we_p0;
    sel_size  = size_p0;
    sel_addr  = addr_p0;
    sel_wdata = wdata_p0;
    if (state == S_IDLE) begin
      sel_we    = we;
      sel_size  = size;
      sel_addr  = addr[AW-1:0];
      sel_wdata = wdata;
    end
  end

  assign sel_bad  = misaligned(sel_size, sel_addr[1:0]);
  assign sel_idx  = sel_addr[AW-1:2];
  assign sel_word = mem[sel_idx];
  assign to_resp  = ((state == S_IDLE) && req && (WAIT == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd0));

  // Stage p0: capture request on acceptance
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && req) begin
      we_p0    <= we;
      size_p0  <= size;
      addr_p0  <= addr[AW-1:0];
      wdata_p0 <= wdata;
    end
  end

  // Store commit on the edge entering RESP; gated by rst so a reset
  // coinciding with that edge discards the store.
  always_ff @(posedge clk) begin
    if (to_resp && rst && sel_we && !sel_bad)
      mem[sel_idx] <= merge_store(sel_word, sel_wdata, sel_size, sel_addr[1:0]);
  end

  // Control FSM and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (WAIT == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Stage p1: response formed on the edge entering RESP
      if (to_resp) begin
        ready <= 1'b1;
        err   <= sel_bad;
        rdata <= (sel_bad || sel_we) ? 32'd0 : extract_load(sel_word, sel_size, sel_addr[1:0]);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  int          sel;

  always #5 clk = ~clk;

  // sel = 1 drives the WAIT=2 instance, sel = 0 the WAIT=0 instance
  logic        req_a, req_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b, busy_a, busy_b;
  logic [31:0] o_rdata;
  logic        o_ready, o_err, o_busy;

  assign req_a   = req && (sel == 1);
  assign req_b   = req && (sel == 0);
  assign o_rdata = (sel == 1) ? rdata_a : rdata_b;
  assign o_ready = (sel == 1) ? ready_a : ready_b;
  assign o_err   = (sel == 1) ? err_a   : err_b;
  assign o_busy  = (sel == 1) ? busy_a  : busy_b;

  data_mem_responder #(.ADDR_W(6), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  data_mem_responder #(.ADDR_W(6), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Byte-level model of each instance's 256-byte address space
  logic [7:0] ref_bytes [2][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ref_access(input int id, input logic w, input logic [1:0] sz,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic e);
    int nb;
    int base;
    nb   = 1 << sz;
    base = int'(a[7:0]);
    e    = ref_bad(sz, a);
    rd   = 32'd0;
    if (e) return;
    for (int k = 0; k < nb; k++) begin
      if (w) ref_bytes[id][(base + k) % 256] = wd[8*k +: 8];
      else   rd[8*k +: 8] = ref_bytes[id][(base + k) % 256];
    end
  endfunction

  task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input bit perturb, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_e, got_e;
    int          lat, wait_n;
    bit          busy_ok;
    wait_n = (sel == 1) ? 2 : 0;
    ref_access(sel, w, sz, a, wd, exp_rd, exp_e);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    lat = 0; busy_ok = 1'b1; rd = 32'd0; got_e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!o_busy) busy_ok = 1'b0;
      if (o_ready) begin
        lat = i; rd = o_rdata; got_e = o_err;
        break;
      end
      if (perturb && i == 1) begin
        @(negedge clk);
        we = ~w; addr = a ^ 32'h30; wdata = ~wd; size = 2'b10;
      end
    end
    @(negedge clk);
    req = 1'b0;
    chk("latency", 32'(lat), 32'(wait_n + 1));
    chk("busy", {31'd0, busy_ok}, 32'd1);
    chk("err", {31'd0, got_e}, {31'd0, exp_e});
    chk("rdata", rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_w0 [3];
    logic [31:0] a_w0 [3];
    logic        dummy_e;
    int          nready, seen;
    logic        exp_r;
    logic [1:0]  sz;
    logic [31:0] a;

    rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0; sel = 1;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst ready", {31'd0, o_ready}, 32'd0);
      chk("rst err",   {31'd0, o_err},   32'd0);
      chk("rst busy",  {31'd0, o_busy},  32'd0);
      chk("rst rdata", o_rdata, 32'd0);
    end
    @(negedge clk); rst = 1'b1;

    // Known contents everywhere
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int wd = 0; wd < 64; wd++) xact(1'b1, 2'd2, 32'(wd * 4), $urandom, 1'b0, rd);
    end

    // Directed, WAIT=2
    sel = 1;
    xact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);        chk("lw 0x10", rd, 32'hDEADBEEF);
    xact(1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, rd);
    xact(1'b1, 2'd0, 32'h21, 32'h000000AA, 1'b0, rd);
    xact(1'b1, 2'd1, 32'h22, 32'h00005566, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd);        chk("lw 0x20", rd, 32'h5566AA44);
    xact(1'b0, 2'd0, 32'h23, 32'h0, 1'b0, rd);        chk("lb 0x23", rd, 32'h00000055);
    xact(1'b0, 2'd1, 32'h20, 32'h0, 1'b0, rd);        chk("lh 0x20", rd, 32'h0000AA44);
    xact(1'b0, 2'd2, 32'h12, 32'h0, 1'b0, rd);
    xact(1'b1, 2'd1, 32'h13, 32'hFFFF, 1'b0, rd);
    xact(1'b1, 2'd3, 32'h10, 32'h0BADF00D, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);        chk("lw 0x10 kept", rd, 32'hDEADBEEF);
    xact(1'b1, 2'd2, 32'h104, 32'hCAFEF00D, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h04, 32'h0, 1'b0, rd);        chk("alias 0x04", rd, 32'hCAFEF00D);
    xact(1'b0, 2'd2, 32'h20, 32'h0, 1'b1, rd);        chk("perturbed lw", rd, 32'h5566AA44);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);        chk("perturb no store", rd, 32'hDEADBEEF);

    // Reset during the wait states of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h08; wdata = 32'h12345678;
    @(posedge clk); #2;
    rst = 1'b0; req = 1'b0;
    #1;
    chk("abort busy",  {31'd0, o_busy},  32'd0);
    chk("abort ready", {31'd0, o_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_ready) seen++;
    end
    chk("abort no ready", 32'(seen), 32'd0);
    xact(1'b0, 2'd2, 32'h08, 32'h0, 1'b0, rd);

    // WAIT=0, req held over three loads
    sel = 0;
    a_w0[0] = 32'h40; a_w0[1] = 32'h44; a_w0[2] = 32'h48;
    for (int k = 0; k < 3; k++) ref_access(0, 1'b0, 2'd2, a_w0[k], 32'h0, exp_w0[k], dummy_e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = a_w0[0];
    nready = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      exp_r = (e % 2 == 1) && (e <= 5);
      chk("w0 ready", {31'd0, o_ready}, {31'd0, exp_r});
      chk("w0 busy",  {31'd0, o_busy},  {31'd0, exp_r});
      if (o_ready) begin
        if (nready < 3) chk("w0 rdata", o_rdata, exp_w0[nready]);
        nready++;
      end
      @(negedge clk);
      if (e == 5) req = 1'b0;
      else if (o_ready && nready < 3) addr = a_w0[nready];
    end
    chk("w0 count", 32'(nready), 32'd3);

    // Random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      repeat (120) begin
        sz = 2'($urandom_range(0, 3));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        xact(1'($urandom_range(0, 1)), sz, a, $urandom, 1'b0, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder for the MIPS core's data-memory port: accepts load/store requests over a req/ready handshake and serves them from an internal word-addressed RAM array.
- Supports sb/sh/sw byte-lane writes and programmable wait states, so pipeline stall logic can be exercised against a non-zero-latency memory.
- Flags misaligned accesses with an error response.
- Sits beside the core, in place of the single-cycle data RAM.

Parameters:
- ADDR_W, 6: word-address bits; depth is 2**ADDR_W words (64 words = 256 bytes).
- WAIT, 2: wait states inserted before the response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  request valid; held high with stable addr/we/size/wdata until ready.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  output  32  load data, zero-extended and right-aligned; sign extension is done by the core.
- ready  output  1  one-cycle response strobe.
- err  output  1  valid with ready; 1 = misaligned or illegal access.
- busy  output  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; ready = 0, err = 0, busy = 0, rdata = 0; wait counter = 0.
  - RAM array is not cleared.
- States and transitions:
  - IDLE: if req, latch addr/we/size/wdata, compute misalign, set busy = 1; go to WAIT if WAIT > 0, else RESP.
  - WAIT: count down WAIT cycles, then go to RESP.
  - RESP: ready = 1 for exactly one cycle; next state IDLE.
- Latency: request accepted in cycle T (IDLE and req high); ready is high in cycle T+1+WAIT.
- Throughput: one request per WAIT+2 cycles. If req is still high in the IDLE cycle after RESP, it is a new request (the core must drop req after ready).
- req is ignored outside IDLE; there is no queuing.
- Misalign conditions: size = 01 with addr[0] = 1; size = 10 with addr[1:0] != 0; size = 11.
  - No RAM access; response carries err = 1 and rdata = 0 at the normal latency.
- Index: addr[ADDR_W+1:2]; upper address bits are ignored, so addresses alias modulo 2**(ADDR_W+2).
- Store:
  - Performed at the clock edge entering RESP.
  - Byte: wdata[7:0] to lane addr[1:0].
  - Half: wdata[15:0] to lane addr[1].
  - Word: full word.
  - Other lanes unchanged. rdata = 0 in the ready cycle.
- Load:
  - The array is read at the edge entering RESP; rdata is registered and valid in the ready cycle.
  - Byte: {24'b0, lane}. Half: {16'b0, half}. Word: full word.
  - rdata holds its value until the next response.
- Read-after-write: a load accepted after a store's ready cycle sees the stored data.
- err is 0 except in the ready cycle of an errored access.
- Reset mid-operation: pending access is abandoned; a store not yet committed is discarded; no ready is issued.

Test Plan:
- rst low then high, WAIT=2; sw addr=0x10, wdata=0xDEADBEEF -> ready high exactly at T+3, err = 0; then lw 0x10 -> rdata = 0xDEADBEEF at T'+3.
- Over word 0x20 = 0x11223344: sb addr=0x21, wdata=0xAA; sh addr=0x22, wdata=0x5566 -> lw 0x20 = 0x5566AA44; lb 0x23 -> rdata = 0x00000055; lh 0x20 -> rdata = 0x0000AA44.
- lw addr=0x12, sh addr=0x13, size=11 -> each gives ready with err = 1, rdata = 0; memory unchanged (lw 0x10 still returns the prior value).
- WAIT=0 build: req held continuously over three loads -> ready every 2nd cycle; busy high in acceptance+1 cycles only; no double service.
- sw addr=0x100+0x04 (alias, ADDR_W=6) -> lw 0x04 returns the stored word; assert rst low during WAIT of sw 0x08 = 0x12345678 -> no ready, busy = 0, lw 0x08 returns the old value.
- Toggle req high while busy with different addr -> ignored; the response reflects the originally latched request.
